// File: rtl/count_pkg.sv
// count_pkg: shared defaults and types for the up/down counter and its
// bench-side reference model.
//   WIDTH     - default counter width
//   MAX_COUNT - default upper bound of the count range (0..MAX_COUNT)
//   count_t   - counter value type at the default width
//   dir_e     - counting direction state
package count_pkg;

  localparam int unsigned WIDTH     = 4;
  localparam int unsigned MAX_COUNT = 11;

  typedef logic [WIDTH-1:0] count_t;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

endpackage

// File: rtl/count_wrap_stat.sv
// count_wrap_stat: saturating statistic counter of wrap events.
//   clock    in   posedge clock
//   reset    in   synchronous active-high reset, clears the count
//   wrap     in   one-cycle wrap event (tc_up or tc_dn of the same edge)
//   wrap_cnt out  number of wrap events since reset, holds at all-ones
module count_wrap_stat #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt
);

  always_ff @(posedge clock) begin
    if (reset) begin
      wrap_cnt <= '0;
    end else if (wrap && (wrap_cnt != '1)) begin
      wrap_cnt <= wrap_cnt + WRAP_W'(1);
    end
  end

endmodule

// File: rtl/updown_count_core.sv
// updown_count_core: synchronous loadable up/down counter, modulo MAX_COUNT+1,
// with wrap, direction-change and load-clamp status pulses.
//   clock    in   posedge clock
//   reset    in   synchronous active-high reset (beats load and count)
//   din      in   load value, clamped to MAX_COUNT
//   load     in   load din this cycle (beats counting)
//   up_down  in   1 = count up, 0 = count down
//   count    out  registered counter value
//   tc_up    out  pulse: up-count wrapped MAX_COUNT -> 0
//   tc_dn    out  pulse: down-count wrapped 0 -> MAX_COUNT
//   load_err out  pulse: loaded din exceeded MAX_COUNT and was clamped
//   dir_chg  out  pulse: counting direction differs from previous counting cycle
//   wrap_cnt out  saturating count of wrap events since reset
module updown_count_core #(
  parameter int unsigned WIDTH     = count_pkg::WIDTH,
  parameter int unsigned MAX_COUNT = count_pkg::MAX_COUNT,
  parameter int unsigned WRAP_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  din,
  input  logic              load,
  input  logic              up_down,
  output logic [WIDTH-1:0]  count,
  output logic              tc_up,
  output logic              tc_dn,
  output logic              load_err,
  output logic              dir_chg,
  output logic [WRAP_W-1:0] wrap_cnt
);

  import count_pkg::*;

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  dir_e             dir_q, dir_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_up_nxt, tc_dn_nxt, load_err_nxt, dir_chg_nxt;
  logic             counting;

  assign counting = !load;

  // Next-count and clamp logic; the wrap compares are explicit so that
  // ranges narrower than 2^WIDTH wrap at MAX_COUNT.
  always_comb begin
    count_nxt    = count;
    tc_up_nxt    = 1'b0;
    tc_dn_nxt    = 1'b0;
    load_err_nxt = 1'b0;
    if (load) begin
      if (din > MAX_C) begin
        count_nxt    = MAX_C;
        load_err_nxt = 1'b1;
      end else begin
        count_nxt = din;
      end
    end else if (up_down) begin
      if (count == MAX_C) begin
        count_nxt = '0;
        tc_up_nxt = 1'b1;
      end else begin
        count_nxt = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        count_nxt = MAX_C;
        tc_dn_nxt = 1'b1;
      end else begin
        count_nxt = count - WIDTH'(1);
      end
    end
  end

  // Direction state machine: next state and change pulse.
  always_comb begin
    dir_nxt     = dir_q;
    dir_chg_nxt = 1'b0;
    if (counting) begin
      dir_nxt     = up_down ? DIR_UP : DIR_DN;
      dir_chg_nxt = (dir_nxt != dir_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dir_q <= DIR_UP;
    end else begin
      dir_q <= dir_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      tc_up    <= 1'b0;
      tc_dn    <= 1'b0;
      load_err <= 1'b0;
      dir_chg  <= 1'b0;
    end else begin
      count    <= count_nxt;
      tc_up    <= tc_up_nxt;
      tc_dn    <= tc_dn_nxt;
      load_err <= load_err_nxt;
      dir_chg  <= dir_chg_nxt;
    end
  end

  // The statistic register shares the reset, so wrap_cnt moves on the same
  // edge as the tc pulse it counts.
  count_wrap_stat #(
    .WRAP_W(WRAP_W)
  ) u_wrap_stat (
    .clock    (clock),
    .reset    (reset),
    .wrap     (tc_up_nxt | tc_dn_nxt),
    .wrap_cnt (wrap_cnt)
  );

endmodule

// File: tb/tb_updown_count_core.sv
// Bench for updown_count_core: directed vector table followed by model-driven
// long runs, all checked through an expected-result queue.
module tb_updown_count_core;

  import count_pkg::*;

  localparam int unsigned TW   = 4;
  localparam int unsigned TMAX = 11;
  localparam int unsigned TWW  = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [TW-1:0]  din   = '0;
  logic           load  = 1'b0;
  logic           up_down = 1'b0;
  logic [TW-1:0]  count;
  logic           tc_up, tc_dn, load_err, dir_chg;
  logic [TWW-1:0] wrap_cnt;

  updown_count_core #(
    .WIDTH(TW),
    .MAX_COUNT(TMAX),
    .WRAP_W(TWW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .din      (din),
    .load     (load),
    .up_down  (up_down),
    .count    (count),
    .tc_up    (tc_up),
    .tc_dn    (tc_dn),
    .load_err (load_err),
    .dir_chg  (dir_chg),
    .wrap_cnt (wrap_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int cnt;
    bit tu;
    bit td;
    bit le;
    bit dc;
    int wc;
  } exp_t;

  typedef struct {
    bit   r;
    bit   l;
    bit   ud;
    int   d;
    exp_t e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int   m_cnt = 0;
  dir_e m_dir = DIR_UP;
  int   m_wc  = 0;

  function automatic exp_t model_step(bit r, bit l, bit ud, int d);
    exp_t e;
    dir_e nd;
    e = '{cnt: 0, tu: 0, td: 0, le: 0, dc: 0, wc: 0};
    if (r) begin
      m_cnt = 0;
      m_dir = DIR_UP;
      m_wc  = 0;
    end else if (l) begin
      if (d > int'(TMAX)) begin
        m_cnt = TMAX;
        e.le  = 1;
      end else begin
        m_cnt = d;
      end
    end else begin
      nd   = ud ? DIR_UP : DIR_DN;
      e.dc = (nd != m_dir);
      m_dir = nd;
      if (ud) begin
        if (m_cnt == int'(TMAX)) begin m_cnt = 0; e.tu = 1; end
        else m_cnt = m_cnt + 1;
      end else begin
        if (m_cnt == 0) begin m_cnt = TMAX; e.td = 1; end
        else m_cnt = m_cnt - 1;
      end
      if ((e.tu || e.td) && m_wc < 255) m_wc = m_wc + 1;
    end
    e.cnt = m_cnt;
    e.wc  = m_wc;
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, queue its expectation, compare after the edge.
  task automatic apply(bit r, bit l, bit ud, int d, exp_t e, bit full);
    exp_t x;
    @(negedge clock);
    reset   = r;
    load    = l;
    up_down = ud;
    din     = TW'(d);
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      x = sb.pop_front();
      check("count", int'(count), x.cnt);
      check("wrap_cnt", int'(wrap_cnt), x.wc);
      if (full) begin
        check("tc_up", int'(tc_up), int'(x.tu));
        check("tc_dn", int'(tc_dn), int'(x.td));
        check("load_err", int'(load_err), int'(x.le));
        check("dir_chg", int'(dir_chg), int'(x.dc));
      end
    end
  endtask

  task automatic model_apply(bit r, bit l, bit ud, int d);
    exp_t e;
    e = model_step(r, l, ud, d);
    apply(r, l, ud, d, e, 1'b1);
  endtask

  function automatic void add(bit r, bit l, bit ud, int d,
                              int c, bit tu, bit td, bit le, bit dc, int wc);
    vec_t v;
    v.r = r; v.l = l; v.ud = ud; v.d = d;
    v.e = '{cnt: c, tu: tu, td: td, le: le, dc: dc, wc: wc};
    vecs.push_back(v);
  endfunction

  initial begin
    exp_t junk;
    // r l ud din | count tu td le dc wrap
    add(1, 0, 1, 0,   0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 11; i++)
      add(0, 0, 1, 0, i, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0,   0, 1, 0, 0, 0, 1);   // 11 -> 0 wrap
    add(0, 0, 1, 0,   1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 3,   3, 0, 0, 0, 0, 1);   // load 3
    add(0, 0, 0, 0,   2, 0, 0, 0, 1, 1);   // first down cycle
    add(0, 0, 0, 0,   1, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,  11, 0, 1, 0, 0, 2);   // 0 -> 11 wrap
    add(0, 0, 0, 0,  10, 0, 0, 0, 0, 2);
    add(0, 1, 0, 14, 11, 0, 0, 1, 0, 2);   // clamped load
    add(0, 0, 1, 0,   0, 1, 0, 0, 1, 3);   // up from 11 after down run
    add(0, 1, 0, 11, 11, 0, 0, 0, 0, 3);
    add(0, 1, 1, 7,   7, 0, 0, 0, 0, 3);   // load beats up at 11
    add(0, 0, 0, 0,   6, 0, 0, 0, 1, 3);
    add(1, 1, 0, 2,   0, 0, 0, 0, 0, 0);   // reset beats load
    add(0, 0, 0, 0,  11, 0, 1, 0, 1, 1);   // first count after reset, down
    add(1, 0, 0, 0,   0, 0, 0, 0, 0, 0);

    reset = 1'b1;
    repeat (2) @(posedge clock);

    foreach (vecs[k]) begin
      junk = model_step(vecs[k].r, vecs[k].l, vecs[k].ud, vecs[k].d);
      apply(vecs[k].r, vecs[k].l, vecs[k].ud, vecs[k].d, vecs[k].e, 1'b1);
    end

    // 300 up cycles from 0: one wrap per 12 counts
    for (int i = 0; i < 300; i++) model_apply(0, 0, 1, 0);
    check("wrap_cnt_300", int'(wrap_cnt), 25);

    // Push well past 255 wraps
    for (int i = 0; i < 12 * 240; i++) model_apply(0, 0, 1, 0);
    check("wrap_cnt_sat", int'(wrap_cnt), 255);
    for (int i = 0; i < 24; i++) model_apply(0, 0, 0, 0);
    check("wrap_cnt_hold", int'(wrap_cnt), 255);

    // Random mix against the model
    model_apply(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      model_apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
    end

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/updown_count_core.md
# updown_count_core

Synchronous loadable up/down counter that is the design-side endpoint of the counter bench interface. It consumes the driver-side stimulus (`din`, `reset`, `up_down`, `load`) and produces the registered `count` sampled by the read monitor. It counts modulo `MAX_COUNT+1` and adds wrap, direction-change and load-error status for scoreboard cross-checks.

## Interface
- `WIDTH`, 4, width of `din` and `count`.
- `MAX_COUNT`, 11, upper bound of the count range; legal values are 0..MAX_COUNT. Must satisfy MAX_COUNT ≤ 2^WIDTH−1.
- `WRAP_W`, 8, width of the wrap-event statistic counter.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  load value.
- `load`  in  1  load `din` this cycle.
- `up_down`  in  1  1 = count up, 0 = count down.
- `count`  out  WIDTH  registered counter value.
- `tc_up`  out  1  one-cycle pulse: up-count wrapped from MAX_COUNT to 0.
- `tc_dn`  out  1  one-cycle pulse: down-count wrapped from 0 to MAX_COUNT.
- `load_err`  out  1  one-cycle pulse: loaded `din` > MAX_COUNT and was clamped.
- `dir_chg`  out  1  one-cycle pulse: `up_down` differs from the previous counting cycle.
- `wrap_cnt`  out  WRAP_W  saturating count of wrap events since reset.

## Operation
- Priority per edge: `reset` > `load` > count.
- Reset: `count`=0, all pulses=0, `wrap_cnt`=0, direction state=DIR_UP. This also applies in the middle of any operation.
- Load:
  - `count` ← `din` if `din` ≤ MAX_COUNT.
  - Otherwise `count` ← MAX_COUNT and `load_err`=1.
  - Load never asserts `tc_up`/`tc_dn` and never updates `wrap_cnt` or the direction state.
- Count, when neither reset nor load is active:
  - Up: at MAX_COUNT → 0 with `tc_up`=1; otherwise +1.
  - Down: at 0 → MAX_COUNT with `tc_dn`=1; otherwise −1.
- Values above MAX_COUNT are unreachable (load is clamped).
- Arithmetic is WIDTH bits. The wrap compare is explicit; it never relies on natural 2^WIDTH rollover unless MAX_COUNT = 2^WIDTH−1.
- Direction state machine (2 states, DIR_UP / DIR_DN):
  - Updates only on counting cycles.
  - Transition to the state given by `up_down`.
  - `dir_chg`=1 when the state changes.
  - The first counting cycle after reset with `up_down`=0 produces `dir_chg`.
- `wrap_cnt`: +1 on each `tc_up` or `tc_dn`; saturates at 2^WRAP_W−1.

## Timing
- Inputs are sampled at posedge N. `count` and all status outputs reflect that sample after posedge N (visible to the read monitor at posedge N+1). Latency is 1 cycle.
- All outputs are registered; no combinational input→output path.
- Pulses last exactly one cycle and are deasserted on any cycle without the triggering event.
- Load and up_down together: load wins, `up_down` is ignored that cycle.
- Reset and load together: reset wins.
- Consecutive loads are each honoured independently.

## Structure
- Package `count_pkg`:
  - `WIDTH`, `MAX_COUNT` defaults.
  - `typedef logic [WIDTH-1:0] count_t`.
  - `typedef enum logic {DIR_UP, DIR_DN} dir_e`.
  - This package is shared with the bench reference model.
- Sub-module `count_wrap_stat`: the saturating `wrap_cnt` counter. Inputs are `clock`, `reset` and the wrap pulse; parameter is `WRAP_W`.
- The top holds the next-count logic, the clamp logic and the direction state machine.

## Test plan
- Reset, then 13 cycles `up_down`=1 → `count` goes 1..11 then 0; `tc_up`=1 exactly on the 11→0 cycle; `wrap_cnt`=1.
- Load `din`=3, then 5 cycles `up_down`=0 → `count` goes 3,2,1,0,11,10; `tc_dn` on the 0→11 cycle; `dir_chg` on the first down cycle.
- Load `din`=14 → `count`=11 and `load_err`=1 for one cycle; next up cycle → `count`=0 with `tc_up`.
- `load`=1 and `up_down`=1 with `count`=11 and `din`=7 → `count`=7; no `tc_up`; `wrap_cnt` unchanged.
- Reset asserted while counting at `count`=6 together with `load`=1, `din`=2 → `count`=0, all pulses 0, `wrap_cnt`=0.
- 300 up cycles from 0 with `WRAP_W`=8 → `wrap_cnt` = 25 (12 counts per wrap); force more than 255 wraps → `wrap_cnt` holds at 255.
